// File: rtl/msk_serial_unmasker.sv
// Serial share recombiner: XOR-folds d shares, one per beat, into one value
// and hands it out over valid/ready, optionally complemented.
module msk_serial_unmasker #(
    parameter int d      = 2,
    parameter int count  = 1,
    parameter bit INVERT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [count-1:0] in_share,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [count-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err,
    input  logic             err_clr
);

    localparam int CW = $clog2(d + 1);
    localparam logic [CW-1:0] LAST = CW'(d - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [count-1:0] acc;
    logic             take;
    logic             fin;
    logic             bad;
    logic             done;

    // A beat offered during clear is thrown away.
    assign take = in_valid & in_ready & ~clear;
    assign fin  = (cnt == LAST);
    assign bad  = take & (in_last ^ fin);
    assign done = take & in_last & fin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE, ACCUM: begin
                    if (bad)       state_nxt = IDLE;
                    else if (done) state_nxt = OUT;
                    else if (take) state_nxt = ACCUM;
                end
                OUT: if (out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state != OUT);
        out_valid = (state == OUT);
    end

    // acc is already zero in IDLE, so one XOR path serves every beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            acc      <= '0;
            out_data <= '0;
            err      <= 1'b0;
        end else begin
            if (clear || bad || done) begin
                cnt <= '0;
                acc <= '0;
            end else if (take) begin
                acc <= acc ^ in_share;
                cnt <= cnt + CW'(1);
            end
            if (done) out_data <= acc ^ in_share ^ {count{INVERT}};
            if (bad)          err <= 1'b1;
            else if (err_clr) err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_msk_serial_unmasker.sv
// Bench for msk_serial_unmasker: four parameterisations on shared stimulus,
// checked each cycle against a share-list model plus directed literal cases.
module tb_msk_serial_unmasker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic       out_ready;
    logic       err_clr;
    logic [7:0] in_share;
    logic       lastv [4];

    logic [3:0] od0, od1, od2;
    logic [7:0] od3;
    logic       ir [4];
    logic       ov [4];
    logic       er [4];
    logic [7:0] odx [4];

    always #5 clk = ~clk;

    assign odx[0] = {4'h0, od0};
    assign odx[1] = {4'h0, od1};
    assign odx[2] = {4'h0, od2};
    assign odx[3] = od3;

    msk_serial_unmasker #(.d(2), .count(4), .INVERT(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_share(in_share[3:0]),
        .in_last(lastv[0]), .in_valid(in_valid), .in_ready(ir[0]),
        .out_data(od0), .out_valid(ov[0]), .out_ready(out_ready),
        .err(er[0]), .err_clr(err_clr));

    msk_serial_unmasker #(.d(2), .count(4), .INVERT(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_share(in_share[3:0]),
        .in_last(lastv[1]), .in_valid(in_valid), .in_ready(ir[1]),
        .out_data(od1), .out_valid(ov[1]), .out_ready(out_ready),
        .err(er[1]), .err_clr(err_clr));

    msk_serial_unmasker #(.d(3), .count(4), .INVERT(1'b0)) u2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_share(in_share[3:0]),
        .in_last(lastv[2]), .in_valid(in_valid), .in_ready(ir[2]),
        .out_data(od2), .out_valid(ov[2]), .out_ready(out_ready),
        .err(er[2]), .err_clr(err_clr));

    msk_serial_unmasker #(.d(1), .count(8), .INVERT(1'b0)) u3 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_share(in_share),
        .in_last(lastv[3]), .in_valid(in_valid), .in_ready(ir[3]),
        .out_data(od3), .out_valid(ov[3]), .out_ready(out_ready),
        .err(er[3]), .err_clr(err_clr));

    int         dd  [4] = '{2, 2, 3, 1};
    logic [7:0] msk [4] = '{8'h0f, 8'h0f, 8'h0f, 8'hff};
    logic [7:0] inv [4] = '{8'h00, 8'h0f, 8'h00, 8'h00};

    // Model: list of shares gathered so far, pending result, sticky error.
    int         n_m  [4];
    logic [7:0] sh_m [4][4];
    logic       ov_m [4];
    logic [7:0] od_m [4];
    logic       er_m [4];

    int total = 0;
    int nbad  = 0;

    task automatic chk8(input string nm, input logic [7:0] act,
                        input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0b want %0b", nm, act, exp);
        end
    endtask

    function automatic void mreset();
        for (int k = 0; k < 4; k++) begin
            n_m[k]  = 0;
            ov_m[k] = 1'b0;
            od_m[k] = 8'h00;
            er_m[k] = 1'b0;
        end
    endfunction

    always @(negedge rst_n) mreset();

    always @(posedge clk) begin : mdl
        logic       ne;
        logic [7:0] s;
        logic [7:0] x;
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                ne = 1'b0;
                s  = in_share & msk[k];
                if (clear) begin
                    n_m[k]  = 0;
                    ov_m[k] = 1'b0;
                end else if (ov_m[k]) begin
                    if (out_ready) ov_m[k] = 1'b0;
                end else if (in_valid) begin
                    if (lastv[k] != (n_m[k] == dd[k] - 1)) begin
                        ne     = 1'b1;
                        n_m[k] = 0;
                    end else if (lastv[k]) begin
                        x = s ^ inv[k];
                        for (int j = 0; j < n_m[k]; j++) x = x ^ sh_m[k][j];
                        od_m[k] = x;
                        ov_m[k] = 1'b1;
                        n_m[k]  = 0;
                    end else begin
                        sh_m[k][n_m[k]] = s;
                        n_m[k]++;
                    end
                end
                if (ne)           er_m[k] = 1'b1;
                else if (err_clr) er_m[k] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            chk1($sformatf("u%0d in_ready", k), ir[k], ~ov_m[k]);
            chk1($sformatf("u%0d out_valid", k), ov[k], ov_m[k]);
            chk8($sformatf("u%0d out_data", k), odx[k], od_m[k]);
            chk1($sformatf("u%0d err", k), er[k], er_m[k]);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic beat(input logic [7:0] s, input logic [3:0] l);
        in_valid = 1'b1;
        in_share = s;
        for (int k = 0; k < 4; k++) lastv[k] = l[k];
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) lastv[k] = 1'b0;
    endtask

    task automatic flush();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        int n;
        mreset();
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        err_clr = 1'b0; in_share = 8'h00;
        for (int k = 0; k < 4; k++) lastv[k] = 1'b0;
        step();
        chk1("reset valid", ov[0], 1'b0);
        chk8("reset data", odx[0], 8'h00);
        chk1("reset err", er[0], 1'b0);
        chk1("reset ready", ir[0], 1'b1);
        step();
        #2 rst_n = 1'b1;
        step();

        // 0xA ^ 0x6
        flush();
        beat(8'h0a, 4'b1000);
        chk1("t1 early valid", ov[0], 1'b0);
        beat(8'h06, 4'b0011);
        chk1("t1 valid", ov[0], 1'b1);
        chk8("t1 data", odx[0], 8'h0c);
        chk8("t1 model", od_m[0], 8'h0c);
        chk8("t1 inv data", odx[1], 8'h03);

        flush();
        beat(8'h03, 4'b1000);
        beat(8'h05, 4'b0011);
        for (int i = 0; i < 3; i++) begin
            chk1("t2 hold valid", ov[1], 1'b1);
            chk8("t2 hold data", odx[1], 8'h09);
            chk1("t2 hold ready", ir[1], 1'b0);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk1("t2 drained valid", ov[1], 1'b0);
        chk8("t2 data held", odx[1], 8'h09);
        chk1("t2 ready back", ir[1], 1'b1);

        flush();
        beat(8'h01, 4'b1000);
        beat(8'h02, 4'b0100);
        chk1("t3 err", er[2], 1'b1);
        chk1("t3 no valid", ov[2], 1'b0);
        beat(8'h01, 4'b1000);
        beat(8'h02, 4'b0000);
        beat(8'h04, 4'b0100);
        chk1("t3 valid", ov[2], 1'b1);
        chk8("t3 data", odx[2], 8'h07);
        chk8("t3 model", od_m[2], 8'h07);
        chk1("t3 err sticky", er[2], 1'b1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk1("t3 err cleared", er[2], 1'b0);

        flush();
        beat(8'h03, 4'b0000);
        clear = 1'b1; in_valid = 1'b1; in_share = 8'h05;
        step();
        clear = 1'b0; in_valid = 1'b0;
        beat(8'h0f, 4'b0000);
        beat(8'h00, 4'b0001);
        chk1("t4 valid", ov[0], 1'b1);
        chk8("t4 data", odx[0], 8'h0f);

        flush();
        beat(8'h01, 4'b0000);
        #2 rst_n = 1'b0;
        #1;
        chk1("t5 accum rst valid", ov[0], 1'b0);
        chk8("t5 accum rst data", odx[0], 8'h00);
        chk1("t5 accum rst err", er[2], 1'b0);
        step();
        #2 rst_n = 1'b1;
        step();
        chk1("t5 ready after rst", ir[0], 1'b1);
        beat(8'h0a, 4'b0000);
        beat(8'h06, 4'b0001);
        chk1("t5 in out", ov[0], 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("t5 out rst valid", ov[0], 1'b0);
        chk8("t5 out rst data", odx[0], 8'h00);
        step();
        #2 rst_n = 1'b1;
        step();
        chk1("t5 ready after rst2", ir[0], 1'b1);

        // d=1 back-to-back: one result every second cycle
        flush();
        out_ready = 1'b1; in_valid = 1'b1; in_share = 8'h5a;
        lastv[3] = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (ov[3]) n++;
            if (i == 0) begin
                chk1("t6 first valid", ov[3], 1'b1);
                chk8("t6 data", odx[3], 8'h5a);
            end
        end
        chk8("t6 results in 8", 8'(n), 8'd4);
        in_valid = 1'b0; out_ready = 1'b0; lastv[3] = 1'b0;
        step();

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                #2 rst_n = 1'b0;
                step();
                #2 rst_n = 1'b1;
            end
            clear     = ($urandom_range(0, 29) == 0);
            err_clr   = ($urandom_range(0, 9) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            in_share  = 8'($urandom);
            for (int k = 0; k < 4; k++) begin
                lastv[k] = (n_m[k] == dd[k] - 1);
                if ($urandom_range(0, 19) == 0) lastv[k] = ~lastv[k];
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, nbad);
        $finish;
    end

endmodule
